// File: rtl/dispense_sequencer.sv
// Beverage dispense sequencer: latches a one-hot drink code and sugar level,
// then times each valve phase in whole seconds from a clock prescaler.
module dispense_sequencer #(
    parameter int CLK_PER_SEC = 50000000,
    parameter int CNT_W       = 26
) (
    input  logic       Clock,
    input  logic       Reset_n,
    input  logic       start,
    input  logic [3:0] cofeeSelection,
    input  logic [1:0] sugar_level,
    input  logic       abort,
    output logic [4:0] status,
    output logic [2:0] phase,
    output logic       busy,
    output logic       done,
    output logic       aborted,
    output logic       sel_err
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WATER  = 3'd1,
        S_COFFEE = 3'd2,
        S_MILK   = 3'd3,
        S_CHOC   = 3'd4,
        S_SUGAR  = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] pres_q, pres_d;
    logic [1:0]       sec_q, sec_d;
    logic [3:0]       sel_q, sel_d;
    logic [1:0]       sugar_q, sugar_d;
    logic [4:0]       status_d;
    logic             aborted_d, sel_err_d;
    logic             last_tick, sel_onehot;
    state_t           nxt;

    // Seconds spent in phase s for a given one-hot recipe; 0 means skipped.
    function automatic logic [1:0] phase_dur(input state_t s, input logic [3:0] sel,
                                             input logic [1:0] sug);
        logic [7:0] tbl;  // {water, coffee, milk, choc}
        case (sel)
            4'b0001: tbl = {2'd2, 2'd3, 2'd0, 2'd0};
            4'b0010: tbl = {2'd2, 2'd2, 2'd1, 2'd0};
            4'b0100: tbl = {2'd2, 2'd1, 2'd2, 2'd0};
            4'b1000: tbl = {2'd1, 2'd1, 2'd1, 2'd2};
            default: tbl = 8'd0;
        endcase
        case (s)
            S_WATER:  return tbl[7:6];
            S_COFFEE: return tbl[5:4];
            S_MILK:   return tbl[3:2];
            S_CHOC:   return tbl[1:0];
            S_SUGAR:  return sug;
            default:  return 2'd0;
        endcase
    endfunction

    // First phase after s with a non-zero duration, or DONE when none remain.
    function automatic state_t next_phase(input state_t s, input logic [3:0] sel,
                                          input logic [1:0] sug);
        state_t r;
        r = S_DONE;
        for (int i = 5; i >= 1; i--) begin
            if (i > int'(s) && phase_dur(state_t'(i[2:0]), sel, sug) != 2'd0)
                r = state_t'(i[2:0]);
        end
        return r;
    endfunction

    assign last_tick  = (pres_q == CNT_W'(CLK_PER_SEC - 1));
    assign sel_onehot = (cofeeSelection != 4'd0) &&
                        ((cofeeSelection & (cofeeSelection - 4'd1)) == 4'd0);

    always_comb begin
        state_d   = state_q;
        pres_d    = pres_q;
        sec_d     = sec_q;
        sel_d     = sel_q;
        sugar_d   = sugar_q;
        aborted_d = 1'b0;
        sel_err_d = 1'b0;
        nxt       = S_DONE;
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    if (sel_onehot) begin
                        sel_d   = cofeeSelection;
                        sugar_d = sugar_level;
                        state_d = S_WATER;
                        pres_d  = '0;
                        sec_d   = phase_dur(S_WATER, cofeeSelection, sugar_level);
                    end else begin
                        sel_err_d = 1'b1;
                    end
                end
            end
            S_WATER, S_COFFEE, S_MILK, S_CHOC, S_SUGAR: begin
                if (abort) begin
                    state_d   = S_IDLE;
                    pres_d    = '0;
                    sec_d     = 2'd0;
                    aborted_d = 1'b1;
                end else if (last_tick) begin
                    pres_d = '0;
                    if (sec_q == 2'd1) begin
                        nxt     = next_phase(state_q, sel_q, sugar_q);
                        state_d = nxt;
                        sec_d   = phase_dur(nxt, sel_q, sugar_q);
                    end else begin
                        sec_d = sec_q - 2'd1;
                    end
                end else begin
                    pres_d = pres_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                pres_d  = '0;
                sec_d   = 2'd0;
            end
        endcase
    end

    always_comb begin
        case (state_d)
            S_WATER:  status_d = 5'b10000;
            S_COFFEE: status_d = 5'b01000;
            S_MILK:   status_d = 5'b00100;
            S_CHOC:   status_d = 5'b00010;
            S_SUGAR:  status_d = 5'b00001;
            default:  status_d = 5'b00000;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            pres_q  <= '0;
            sec_q   <= 2'd0;
            sel_q   <= 4'd0;
            sugar_q <= 2'd0;
            status  <= 5'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            aborted <= 1'b0;
            sel_err <= 1'b0;
        end else begin
            state_q <= state_d;
            pres_q  <= pres_d;
            sec_q   <= sec_d;
            sel_q   <= sel_d;
            sugar_q <= sugar_d;
            status  <= status_d;
            busy    <= (state_d != S_IDLE);
            done    <= (state_d == S_DONE);
            aborted <= aborted_d;
            sel_err <= sel_err_d;
        end
    end

    assign phase = state_q;

endmodule

// File: tb/tb_dispense_sequencer.sv
// Directed bench for dispense_sequencer with a recipe-schedule model checked
// every cycle, plus literal phase-length checks per scenario.
module tb_dispense_sequencer;

    localparam int CPS = 4;

    logic       Clock;
    logic       Reset_n;
    logic       start;
    logic [3:0] cofeeSelection;
    logic [1:0] sugar_level;
    logic       abort;
    logic [4:0] status;
    logic [2:0] phase;
    logic       busy, done, aborted, sel_err;

    dispense_sequencer #(.CLK_PER_SEC(CPS), .CNT_W(3)) dut (
        .Clock(Clock), .Reset_n(Reset_n), .start(start),
        .cofeeSelection(cofeeSelection), .sugar_level(sugar_level), .abort(abort),
        .status(status), .phase(phase), .busy(busy), .done(done),
        .aborted(aborted), .sel_err(sel_err)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int n_cmp = 0;
    int n_fail = 0;

    // Model: each accepted drink expands into a per-cycle schedule of outputs.
    typedef struct packed {
        logic [4:0] st;
        logic [2:0] ph;
        logic       dn;
    } ent_t;

    ent_t sched[$];
    int   water_s[4]  = '{2, 2, 2, 1};
    int   coffee_s[4] = '{3, 2, 1, 1};
    int   milk_s[4]   = '{0, 1, 2, 1};
    int   choc_s[4]   = '{0, 0, 0, 2};

    logic [4:0] exp_status;
    logic [2:0] exp_phase;
    logic       exp_busy, exp_done, exp_aborted, exp_sel_err;

    task automatic build_sched(input logic [3:0] sel, input logic [1:0] sug);
        int idx;
        int durs[5];
        ent_t e;
        idx = 0;
        for (int b = 0; b < 4; b++) if (sel[b]) idx = b;
        durs[0] = water_s[idx];
        durs[1] = coffee_s[idx];
        durs[2] = milk_s[idx];
        durs[3] = choc_s[idx];
        durs[4] = int'(sug);
        for (int p = 0; p < 5; p++) begin
            for (int k = 0; k < durs[p] * CPS; k++) begin
                e.st = 5'b10000 >> p;
                e.ph = 3'(p + 1);
                e.dn = 1'b0;
                sched.push_back(e);
            end
        end
        e.st = 5'b00000;
        e.ph = 3'd6;
        e.dn = 1'b1;
        sched.push_back(e);
    endtask

    initial begin
        ent_t e;
        logic [2:0] pre_phase;
        exp_status = '0; exp_phase = '0; exp_busy = 0;
        exp_done = 0; exp_aborted = 0; exp_sel_err = 0;
        forever begin
            @(posedge Clock or negedge Reset_n);
            if (!Reset_n) begin
                sched.delete();
                exp_status = '0; exp_phase = '0; exp_busy = 0;
                exp_done = 0; exp_aborted = 0; exp_sel_err = 0;
            end else begin
                pre_phase   = exp_phase;
                exp_aborted = 0;
                exp_sel_err = 0;
                if (pre_phase == 3'd0) begin
                    if (start && !abort) begin
                        if ($countones(cofeeSelection) == 1) build_sched(cofeeSelection, sugar_level);
                        else exp_sel_err = 1;
                    end
                end else if (abort && pre_phase >= 3'd1 && pre_phase <= 3'd5) begin
                    sched.delete();
                    exp_aborted = 1;
                end
                if (sched.size() > 0) begin
                    e = sched.pop_front();
                    exp_status = e.st; exp_phase = e.ph; exp_done = e.dn; exp_busy = 1;
                end else begin
                    exp_status = '0; exp_phase = '0; exp_done = 0; exp_busy = 0;
                end
            end
        end
    end

    // Per-cycle comparison against the model
    initial begin
        forever begin
            @(negedge Clock);
            if (Reset_n) begin
                n_cmp++;
                if ({status, phase, busy, done, aborted, sel_err} !==
                    {exp_status, exp_phase, exp_busy, exp_done, exp_aborted, exp_sel_err}) begin
                    n_fail++;
                    $display("FAIL cycle t=%0t: got st=%b ph=%0d busy=%b done=%b ab=%b se=%b, expected st=%b ph=%0d busy=%b done=%b ab=%b se=%b",
                             $time, status, phase, busy, done, aborted, sel_err,
                             exp_status, exp_phase, exp_busy, exp_done, exp_aborted, exp_sel_err);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    int cnt_w, cnt_c, cnt_m, cnt_ch, cnt_s, cnt_done, cnt_ab, cnt_se, cnt_busy, done_idx;

    task automatic run_window(input int n);
        cnt_w = 0; cnt_c = 0; cnt_m = 0; cnt_ch = 0; cnt_s = 0;
        cnt_done = 0; cnt_ab = 0; cnt_se = 0; cnt_busy = 0; done_idx = -1;
        for (int i = 0; i < n; i++) begin
            @(negedge Clock);
            case (status)
                5'b10000: cnt_w++;
                5'b01000: cnt_c++;
                5'b00100: cnt_m++;
                5'b00010: cnt_ch++;
                5'b00001: cnt_s++;
                default: ;
            endcase
            if (done) begin
                cnt_done++;
                if (done_idx < 0) done_idx = i;
            end
            if (aborted) cnt_ab++;
            if (sel_err) cnt_se++;
            if (busy) cnt_busy++;
        end
    endtask

    task automatic pulse_start(input logic [3:0] sel, input logic [1:0] sug);
        @(posedge Clock); #2;
        start = 1'b1; cofeeSelection = sel; sugar_level = sug;
        @(posedge Clock); #2;
        start = 1'b0;
    endtask

    initial begin
        Reset_n = 1'b0; start = 1'b0; cofeeSelection = 4'd0; sugar_level = 2'd0; abort = 1'b0;
        repeat (3) @(posedge Clock);
        #1;
        chk("reset_outputs", int'({status, phase, busy, done, aborted, sel_err}), 0);
        #2 Reset_n = 1'b1;
        repeat (2) @(posedge Clock);

        // Espresso, sugar 1
        pulse_start(4'b0001, 2'd1);
        run_window(30);
        chk("esp_water", cnt_w, 8);
        chk("esp_coffee", cnt_c, 12);
        chk("esp_sugar", cnt_s, 4);
        chk("esp_done_idx", done_idx, 24);
        chk("esp_busy", cnt_busy, 25);

        // Mocha, sugar 0
        pulse_start(4'b1000, 2'd0);
        run_window(26);
        chk("mocha_water", cnt_w, 4);
        chk("mocha_coffee", cnt_c, 4);
        chk("mocha_milk", cnt_m, 4);
        chk("mocha_choc", cnt_ch, 8);
        chk("mocha_sugar", cnt_s, 0);
        chk("mocha_done_idx", done_idx, 20);

        // Cappuccino, inputs disturbed mid-drink
        pulse_start(4'b0100, 2'd2);
        fork
            run_window(35);
            begin
                repeat (4) @(posedge Clock);
                #2 cofeeSelection = 4'b1000; sugar_level = 2'd3;
                repeat (9) @(posedge Clock);
                #2 start = 1'b1;
                @(posedge Clock);
                #2 start = 1'b0;
            end
        join
        chk("cap_water", cnt_w, 8);
        chk("cap_coffee", cnt_c, 4);
        chk("cap_milk", cnt_m, 8);
        chk("cap_sugar", cnt_s, 8);
        chk("cap_done_idx", done_idx, 28);
        chk("cap_sel_err", cnt_se, 0);
        chk("cap_done_cnt", cnt_done, 1);

        // Illegal selections
        fork
            run_window(8);
            begin
                pulse_start(4'b0000, 2'd0);
                pulse_start(4'b0011, 2'd0);
            end
        join
        chk("ill_sel_err", cnt_se, 2);
        chk("ill_busy", cnt_busy, 0);
        chk("ill_status", cnt_w + cnt_c + cnt_m + cnt_ch + cnt_s, 0);

        // Abort three cycles into COFFEE
        pulse_start(4'b0001, 2'd0);
        fork
            run_window(12);
            begin
                repeat (10) @(posedge Clock);
                #2 abort = 1'b1;
                @(posedge Clock);
                #2 abort = 1'b0;
            end
        join
        chk("abort_coffee", cnt_c, 3);
        chk("abort_pulse", cnt_ab, 1);
        chk("abort_done", cnt_done, 0);
        chk("abort_busy", cnt_busy, 11);
        pulse_start(4'b0001, 2'd0);
        run_window(25);
        chk("after_abort_water", cnt_w, 8);
        chk("after_abort_coffee", cnt_c, 12);
        chk("after_abort_done_idx", done_idx, 20);

        // Asynchronous reset mid-WATER
        pulse_start(4'b0010, 2'd1);
        repeat (3) @(posedge Clock);
        #3 Reset_n = 1'b0;
        #1;
        chk("async_reset_outputs", int'({status, phase, busy, done, aborted, sel_err}), 0);
        repeat (2) @(posedge Clock);
        #3 Reset_n = 1'b1;
        pulse_start(4'b0010, 2'd1);
        run_window(30);
        chk("post_reset_water", cnt_w, 8);
        chk("post_reset_coffee", cnt_c, 8);
        chk("post_reset_milk", cnt_m, 4);
        chk("post_reset_sugar", cnt_s, 4);
        chk("post_reset_done_idx", done_idx, 24);

        repeat (3) @(posedge Clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
